ahbl_2m_arbiter: RTL and testbench
==================================

Name: ahbl_2m_arbiter

Overview:
- Two-master to one-slave AHB-Lite arbiter that sits directly downstream of the DMA controller's master port.
- Master 0 (CPU) and master 1 (DMAC) share one AHB-Lite path into the system bus/slave mux.
- AHB-Lite masters have no grant signal, so a losing master is stalled by driving its HREADY low.
- A losing master's address phase is captured in a per-master hold register and replayed when it wins.

Parameters:
PRIORITY_MODE, 0, 0 = fixed priority (M1/DMAC wins contention), 1 = round-robin.

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; asynchronous, active-low
m0HADDR, m1HADDR  in  32  master address
m0HTRANS, m1HTRANS  in  2  master transfer type
m0HSIZE, m1HSIZE  in  3  master size
m0HWRITE, m1HWRITE  in  1  master write
m0HWDATA, m1HWDATA  in  32  master write data
m0HREADY, m1HREADY  out  1  ready returned to each master
m0HRDATA, m1HRDATA  out  32  read data returned to each master
HADDR  out  32  bus address
HTRANS  out  2  bus transfer type
HSIZE  out  3  bus size
HWRITE  out  1  bus write
HWDATA  out  32  bus write data
HREADY  in  1  bus ready
HRDATA  in  32  bus read data
HMASTER  out  1  owner of the current data phase

Behaviour:
- State:
  - hold_valid_x, hold_addr_x, hold_size_x, hold_write_x for x = 0, 1.
  - dph_valid, dph_owner.
  - lock_valid, lock_owner.
  - last_gnt (round-robin pointer).
- Reset: all state 0. Outputs settle to HTRANS=IDLE, m0HREADY=m1HREADY=1, HMASTER=0.
- mxHREADY:
  - 0 when hold_valid_x=1.
  - Else equals HREADY when dph_valid and dph_owner=x.
  - Else 1.
- mxHRDATA = HRDATA (broadcast); only the data-phase owner consumes it.
- Request: req_x = hold_valid_x | (mxHREADY & mxHTRANS[1]).
- Address source: hold registers when hold_valid_x, else live inputs.
- Grant (combinational, gnt):
  - If lock_valid: gnt = lock_owner.
  - Else, with a single requester: that requester.
  - Else, on contention: M1 when PRIORITY_MODE=0; when PRIORITY_MODE=1, the master that is not last_gnt.
- Bus address phase:
  - HTRANS = NONSEQ (2'b10) whenever req_gnt=1, else IDLE.
  - SEQ is never forwarded; interleaved transfers make bursts non-contiguous.
  - HADDR, HSIZE, HWRITE come from gnt's source.
  - With no requests, HADDR/HSIZE/HWRITE follow M0 live inputs.
- Lock: if HTRANS=NONSEQ and HREADY=0, then lock_valid<=1 and lock_owner<=gnt. This holds the presented address stable across wait states. Lock clears on HREADY=1.
- Capture: master x is captured into hold_x (hold_valid_x<=1) when both hold:
  - mxHREADY=1 and mxHTRANS[1]=1, and
  - NOT (gnt=x and HREADY=1).
- Acceptance: on a rising edge with HREADY=1 and HTRANS=NONSEQ:
  - dph_valid<=1, dph_owner<=gnt, last_gnt<=gnt.
  - hold_valid_gnt<=0.
- Idle edge: on a rising edge with HREADY=1 and no request, dph_valid<=0.
- Data phase:
  - HWDATA = dph_owner ? m1HWDATA : m0HWDATA.
  - HMASTER = dph_owner.
- Latency:
  - Uncontended request reaches the bus in the same cycle (zero added latency).
  - A losing master stalls for at least one cycle per competing transfer.
- Simultaneous events:
  - A hold capture and an acceptance of the other master on the same edge both occur.
  - A master's own pipelined address while its data phase waits is not a request (its HREADY=0); it is re-evaluated when HREADY rises.
- No HRESP/error handling; the slave side is always OKAY.
- Reset mid-transfer: all hold, lock and data-phase state is discarded immediately (asynchronous). Masters must also be in reset.

Test Plan:
1. M0 read 0x0000_1000 alone, HREADY=1, HRDATA=0xCAFE0001 -> HADDR=0x1000/NONSEQ same cycle; m0HRDATA=0xCAFE0001 next cycle; m0HREADY stays 1; HMASTER=0.
2. PRIORITY_MODE=0, same cycle M0 write 0x2000 data 0x11 and M1 write 0x3000 data 0x22 ->
   - bus 0x3000 then 0x2000 on consecutive cycles;
   - HWDATA 0x22 then 0x11;
   - m0HREADY=0 for exactly 1 cycle; hold_valid_0 set then cleared.
3. PRIORITY_MODE=1, both masters issuing 4 back-to-back NONSEQ reads -> grant order M0,M1,M0,M1,...; no master waits more than one transfer.
4. M1 data phase with 2 wait states while M0 requests 0x4000 -> HADDR=0x4000 held constant through both waits; m1HREADY=0 for 2 cycles; M0 accepted on the edge HREADY=1.
5. HRESETn asserted while hold_valid_0=1 and dph_valid=1 -> immediately HTRANS=IDLE, m0HREADY=m1HREADY=1, HMASTER=0; first transfer after release proceeds with zero added latency.

Source files
------------

// File: rtl/ahbl_2m_arbiter.sv
// ahbl_2m_arbiter: shares one AHB-Lite path between M0 (CPU) and M1 (DMAC).
// AHB-Lite masters have no grant, so a losing master is stalled through its own
// HREADY. Its address phase is parked in a hold register and replayed later as
// a NONSEQ. SEQ is never forwarded because interleaving breaks burst contiguity.
module ahbl_2m_arbiter #(
   parameter int PRIORITY_MODE = 0   // 0: M1 wins contention, 1: round-robin
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] m0HADDR,
   input  logic [1:0]  m0HTRANS,
   input  logic [2:0]  m0HSIZE,
   input  logic        m0HWRITE,
   input  logic [31:0] m0HWDATA,
   output logic        m0HREADY,
   output logic [31:0] m0HRDATA,
   input  logic [31:0] m1HADDR,
   input  logic [1:0]  m1HTRANS,
   input  logic [2:0]  m1HSIZE,
   input  logic        m1HWRITE,
   input  logic [31:0] m1HWDATA,
   output logic        m1HREADY,
   output logic [31:0] m1HRDATA,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic        HMASTER
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic        hold_valid_0, hold_valid_1;
   logic [31:0] hold_addr_0, hold_addr_1;
   logic [2:0]  hold_size_0, hold_size_1;
   logic        hold_write_0, hold_write_1;
   logic        dph_valid, dph_owner;
   logic        lock_valid, lock_owner;
   logic        last_gnt;

   logic        req_0, req_1;
   logic        gnt, req_gnt, accept;
   logic        capture_0, capture_1;

   // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ; every request is replayed as NONSEQ
   logic unused_trans;
   assign unused_trans = ^{m0HTRANS[0], m1HTRANS[0]};

   // Ready back to each master: stalled while parked, else tracks the bus in its own data phase
   always_comb begin
      m0HREADY = 1'b1;
      m1HREADY = 1'b1;
      if (hold_valid_0)                 m0HREADY = 1'b0;
      else if (dph_valid && !dph_owner) m0HREADY = HREADY;
      if (hold_valid_1)                 m1HREADY = 1'b0;
      else if (dph_valid && dph_owner)  m1HREADY = HREADY;
   end

   assign m0HRDATA = HRDATA;
   assign m1HRDATA = HRDATA;

   // A parked transfer always requests; a live one only when the master sees ready
   assign req_0 = hold_valid_0 | (m0HREADY & m0HTRANS[1]);
   assign req_1 = hold_valid_1 | (m1HREADY & m1HTRANS[1]);

   // Grant: a presented address stays owned through wait states, then priority/round-robin
   always_comb begin
      gnt = 1'b0;
      if (lock_valid)
         gnt = lock_owner;
      else if (req_0 && req_1)
         gnt = (PRIORITY_MODE == 0) ? 1'b1 : ~last_gnt;
      else if (req_1)
         gnt = 1'b1;
   end

   assign req_gnt = gnt ? req_1 : req_0;
   assign accept  = HREADY & req_gnt;

   // Bus address phase from the granted master's source (hold register or live inputs)
   always_comb begin
      HTRANS = req_gnt ? TRANS_NONSEQ : TRANS_IDLE;
      if (gnt) begin
         HADDR  = hold_valid_1 ? hold_addr_1  : m1HADDR;
         HSIZE  = hold_valid_1 ? hold_size_1  : m1HSIZE;
         HWRITE = hold_valid_1 ? hold_write_1 : m1HWRITE;
      end else begin
         HADDR  = hold_valid_0 ? hold_addr_0  : m0HADDR;
         HSIZE  = hold_valid_0 ? hold_size_0  : m0HSIZE;
         HWRITE = hold_valid_0 ? hold_write_0 : m0HWRITE;
      end
   end

   // Write data and owner follow whoever holds the current data phase
   assign HWDATA  = dph_owner ? m1HWDATA : m0HWDATA;
   assign HMASTER = dph_owner;

   // A live transfer that does not complete on the bus this edge must be parked
   assign capture_0 = m0HREADY & m0HTRANS[1] & ~(~gnt & HREADY);
   assign capture_1 = m1HREADY & m1HTRANS[1] & ~( gnt & HREADY);

   // M0 hold register: park on capture, release once its replay is accepted
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_valid_0 <= 1'b0;
         hold_addr_0  <= '0;
         hold_size_0  <= '0;
         hold_write_0 <= 1'b0;
      end else if (capture_0) begin
         hold_valid_0 <= 1'b1;
         hold_addr_0  <= m0HADDR;
         hold_size_0  <= m0HSIZE;
         hold_write_0 <= m0HWRITE;
      end else if (accept && !gnt) begin
         hold_valid_0 <= 1'b0;
      end
   end

   // M1 hold register: park on capture, release once its replay is accepted
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_valid_1 <= 1'b0;
         hold_addr_1  <= '0;
         hold_size_1  <= '0;
         hold_write_1 <= 1'b0;
      end else if (capture_1) begin
         hold_valid_1 <= 1'b1;
         hold_addr_1  <= m1HADDR;
         hold_size_1  <= m1HSIZE;
         hold_write_1 <= m1HWRITE;
      end else if (accept && gnt) begin
         hold_valid_1 <= 1'b0;
      end
   end

   // Data-phase ownership, round-robin pointer and address lock across wait states
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dph_valid  <= 1'b0;
         dph_owner  <= 1'b0;
         last_gnt   <= 1'b0;
         lock_valid <= 1'b0;
         lock_owner <= 1'b0;
      end else begin
         if (accept) begin
            dph_valid <= 1'b1;
            dph_owner <= gnt;
            last_gnt  <= gnt;
         end else if (HREADY && !(req_0 || req_1)) begin
            dph_valid <= 1'b0;
         end
         if (req_gnt && !HREADY) begin
            lock_valid <= 1'b1;
            lock_owner <= gnt;
         end else if (HREADY) begin
            lock_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_2m_arbiter.sv
// tb_ahbl_2m_arbiter: fixed-priority and round-robin instances share stimulus.
// Directed cycle tables with hand-derived expectations, a reset-in-flight
// sequence, then random traffic against a per-master reference model.
module tb_ahbl_2m_arbiter;

   logic        HCLK, HRESETn;
   logic [31:0] m0HADDR, m1HADDR, m0HWDATA, m1HWDATA, HRDATA;
   logic [1:0]  m0HTRANS, m1HTRANS;
   logic [2:0]  m0HSIZE, m1HSIZE;
   logic        m0HWRITE, m1HWRITE, HREADY;

   logic        o_m0rdy [2], o_m1rdy [2], o_hwrite [2], o_hmaster [2];
   logic [31:0] o_m0rdata [2], o_m1rdata [2], o_haddr [2], o_hwdata [2];
   logic [1:0]  o_htrans [2];
   logic [2:0]  o_hsize [2];

   int checks = 0;
   int errors = 0;

   ahbl_2m_arbiter #(.PRIORITY_MODE(0)) u_fix (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .m0HADDR(m0HADDR), .m0HTRANS(m0HTRANS), .m0HSIZE(m0HSIZE), .m0HWRITE(m0HWRITE),
      .m0HWDATA(m0HWDATA), .m0HREADY(o_m0rdy[0]), .m0HRDATA(o_m0rdata[0]),
      .m1HADDR(m1HADDR), .m1HTRANS(m1HTRANS), .m1HSIZE(m1HSIZE), .m1HWRITE(m1HWRITE),
      .m1HWDATA(m1HWDATA), .m1HREADY(o_m1rdy[0]), .m1HRDATA(o_m1rdata[0]),
      .HADDR(o_haddr[0]), .HTRANS(o_htrans[0]), .HSIZE(o_hsize[0]), .HWRITE(o_hwrite[0]),
      .HWDATA(o_hwdata[0]), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(o_hmaster[0]));

   ahbl_2m_arbiter #(.PRIORITY_MODE(1)) u_rr (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .m0HADDR(m0HADDR), .m0HTRANS(m0HTRANS), .m0HSIZE(m0HSIZE), .m0HWRITE(m0HWRITE),
      .m0HWDATA(m0HWDATA), .m0HREADY(o_m0rdy[1]), .m0HRDATA(o_m0rdata[1]),
      .m1HADDR(m1HADDR), .m1HTRANS(m1HTRANS), .m1HSIZE(m1HSIZE), .m1HWRITE(m1HWRITE),
      .m1HWDATA(m1HWDATA), .m1HREADY(o_m1rdy[1]), .m1HRDATA(o_m1rdata[1]),
      .HADDR(o_haddr[1]), .HTRANS(o_htrans[1]), .HSIZE(o_hsize[1]), .HWRITE(o_hwrite[1]),
      .HWDATA(o_hwdata[1]), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(o_hmaster[1]));

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      bit          rst;     // reset before this row
      int          dut;     // 0 fixed priority, 1 round-robin
      logic [1:0]  t0, t1;
      logic [31:0] a0, a1, d0, d1;
      logic        w0, w1, rdy;
      logic [31:0] rdata;
      logic [1:0]  e_trans;
      logic [31:0] e_addr, e_wdata;
      logic        e_mst, e_r0, e_r1;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t row(input int rst, input int dut,
                                input int t0, input logic [31:0] a0, input int w0, input logic [31:0] d0,
                                input int t1, input logic [31:0] a1, input int w1, input logic [31:0] d1,
                                input int rdy, input logic [31:0] rdata,
                                input int e_trans, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input int e_mst, input int e_r0, input int e_r1);
      vec_t v;
      v.rst = (rst != 0); v.dut = dut;
      v.t0 = 2'(t0); v.a0 = a0; v.w0 = (w0 != 0); v.d0 = d0;
      v.t1 = 2'(t1); v.a1 = a1; v.w1 = (w1 != 0); v.d1 = d1;
      v.rdy = (rdy != 0); v.rdata = rdata;
      v.e_trans = 2'(e_trans); v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.e_mst = (e_mst != 0); v.e_r0 = (e_r0 != 0); v.e_r1 = (e_r1 != 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (per instance, per master) ----------------
   bit          md_held  [2][2];
   logic [31:0] md_haddr [2][2];
   logic [2:0]  md_hsize [2][2];
   logic        md_hwr   [2][2];
   int          md_busy [2], md_owner [2], md_lock [2], md_lockown [2], md_last [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int m = 0; m < 2; m++) begin
            md_held[d][m] = 1'b0; md_haddr[d][m] = '0; md_hsize[d][m] = '0; md_hwr[d][m] = 1'b0;
         end
         md_busy[d] = 0; md_owner[d] = 0; md_lock[d] = 0; md_lockown[d] = 0; md_last[d] = 0;
      end
   endtask

   // Check one instance for the current cycle, then advance its model across the edge
   task automatic model_step(input int d, input int cyc);
      logic [1:0]  tr [2];
      logic [31:0] ad [2], wd [2];
      logic [2:0]  sz [2];
      logic        wr [2];
      int          rdy [2], req [2];
      int          nreq, win, bv;
      string       pre;
      tr[0] = m0HTRANS; ad[0] = m0HADDR; sz[0] = m0HSIZE; wr[0] = m0HWRITE; wd[0] = m0HWDATA;
      tr[1] = m1HTRANS; ad[1] = m1HADDR; sz[1] = m1HSIZE; wr[1] = m1HWRITE; wd[1] = m1HWDATA;
      for (int m = 0; m < 2; m++) begin
         if (md_held[d][m])                         rdy[m] = 0;
         else if (md_busy[d] != 0 && md_owner[d] == m) rdy[m] = HREADY ? 1 : 0;
         else                                       rdy[m] = 1;
         req[m] = (md_held[d][m] || (rdy[m] == 1 && tr[m][1])) ? 1 : 0;
      end
      nreq = req[0] + req[1];
      if (md_lock[d] != 0) win = md_lockown[d];
      else if (nreq == 2)  win = (d == 0) ? 1 : 1 - md_last[d];
      else                 win = req[1];
      bv  = req[win];
      pre = $sformatf("rnd inst%0d cyc%0d", d, cyc);
      chk({pre, " HTRANS"},   32'(o_htrans[d]),  bv ? 32'h2 : 32'h0);
      chk({pre, " HADDR"},    o_haddr[d],        md_held[d][win] ? md_haddr[d][win] : ad[win]);
      chk({pre, " HSIZE"},    32'(o_hsize[d]),   32'(md_held[d][win] ? md_hsize[d][win] : sz[win]));
      chk({pre, " HWRITE"},   32'(o_hwrite[d]),  32'(md_held[d][win] ? md_hwr[d][win] : wr[win]));
      chk({pre, " HWDATA"},   o_hwdata[d],       wd[md_owner[d]]);
      chk({pre, " HMASTER"},  32'(o_hmaster[d]), 32'(md_owner[d]));
      chk({pre, " m0HREADY"}, 32'(o_m0rdy[d]),   32'(rdy[0]));
      chk({pre, " m1HREADY"}, 32'(o_m1rdy[d]),   32'(rdy[1]));
      chk({pre, " m1HRDATA"}, o_m1rdata[d],      HRDATA);
      for (int m = 0; m < 2; m++)
         if (rdy[m] == 1 && tr[m][1] && !(win == m && HREADY)) begin
            md_held[d][m] = 1'b1; md_haddr[d][m] = ad[m]; md_hsize[d][m] = sz[m]; md_hwr[d][m] = wr[m];
         end
      if (bv != 0 && HREADY) begin
         md_busy[d] = 1; md_owner[d] = win; md_last[d] = win; md_held[d][win] = 1'b0;
      end else if (HREADY && nreq == 0) begin
         md_busy[d] = 0;
      end
      if (bv != 0 && !HREADY) begin
         md_lock[d] = 1; md_lockown[d] = win;
      end else if (HREADY) begin
         md_lock[d] = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      m0HTRANS = 2'b00; m0HADDR = '0; m0HSIZE = 3'b010; m0HWRITE = 1'b0; m0HWDATA = '0;
      m1HTRANS = 2'b00; m1HADDR = '0; m1HSIZE = 3'b010; m1HWRITE = 1'b0; m1HWDATA = '0;
      HREADY = 1'b1; HRDATA = '0;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      set_idle();
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      model_reset();
   endtask

   task automatic apply(input vec_t v);
      m0HTRANS = v.t0; m0HADDR = v.a0; m0HWRITE = v.w0; m0HWDATA = v.d0; m0HSIZE = 3'b010;
      m1HTRANS = v.t1; m1HADDR = v.a1; m1HWRITE = v.w1; m1HWDATA = v.d1; m1HSIZE = 3'b010;
      HREADY = v.rdy; HRDATA = v.rdata;
   endtask

   localparam int N = 2;
   localparam int I = 0;

   initial begin
      vec_t v;
      // M0 read alone: same-cycle bus address, data next cycle
      vq.push_back(row(1,0, N,32'h1000,0,0,  I,0,0,0,  1,32'h0,        N,32'h1000,0,0,1,1));
      vq.push_back(row(0,0, I,0,0,0,         I,0,0,0,  1,32'hCAFE0001, I,0,0,0,1,1));
      // Fixed priority contention: M1 first, M0 replayed from hold, write data follows owner
      vq.push_back(row(1,0, N,32'h2000,1,0,     N,32'h3000,1,0,     1,0, N,32'h3000,0,0,1,1));
      vq.push_back(row(0,0, I,0,1,32'h11,       I,0,0,32'h22,       1,0, N,32'h2000,32'h22,1,0,1));
      vq.push_back(row(0,0, I,0,0,32'h11,       I,0,0,0,            1,0, I,0,32'h11,0,1,1));
      // Round-robin: one M1 transfer to point last grant at M1, then 4+4 back-to-back reads
      vq.push_back(row(1,1, I,0,0,0,        N,32'h5000,0,0, 1,0, N,32'h5000,0,0,1,1));
      vq.push_back(row(0,1, N,32'h100,0,0,  N,32'h200,0,0,  1,0, N,32'h100,0,1,1,1));
      vq.push_back(row(0,1, N,32'h104,0,0,  N,32'h204,0,0,  1,0, N,32'h200,0,0,1,0));
      vq.push_back(row(0,1, N,32'h108,0,0,  N,32'h204,0,0,  1,0, N,32'h104,0,1,0,1));
      vq.push_back(row(0,1, N,32'h108,0,0,  N,32'h208,0,0,  1,0, N,32'h204,0,0,1,0));
      vq.push_back(row(0,1, N,32'h10C,0,0,  N,32'h208,0,0,  1,0, N,32'h108,0,1,0,1));
      vq.push_back(row(0,1, N,32'h10C,0,0,  N,32'h20C,0,0,  1,0, N,32'h208,0,0,1,0));
      vq.push_back(row(0,1, I,0,0,0,        N,32'h20C,0,0,  1,0, N,32'h10C,0,1,0,1));
      vq.push_back(row(0,1, I,0,0,0,        I,0,0,0,        1,0, N,32'h20C,0,0,1,0));
      vq.push_back(row(0,1, I,0,0,0,        I,0,0,0,        1,0, I,0,0,1,1,1));
      // M1 data phase with two wait states: M0 address locked on the bus, accepted on ready
      vq.push_back(row(1,0, I,0,0,0,         N,32'h6000,0,0, 1,0, N,32'h6000,0,0,1,1));
      vq.push_back(row(0,0, N,32'h4000,0,0,  I,0,0,0,        0,0, N,32'h4000,0,1,1,0));
      vq.push_back(row(0,0, I,0,0,0,         I,0,0,0,        0,0, N,32'h4000,0,1,0,0));
      vq.push_back(row(0,0, I,0,0,0,         I,0,0,0,        1,0, N,32'h4000,0,1,0,1));
      vq.push_back(row(0,0, I,0,0,0,         I,0,0,0,        1,0, I,0,0,0,1,1));

      // Reset state, sampled while reset is held
      HRESETn = 1'b0;
      set_idle();
      model_reset();
      @(negedge HCLK);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset inst%0d HTRANS", d),   32'(o_htrans[d]),  32'h0);
         chk($sformatf("reset inst%0d m0HREADY", d), 32'(o_m0rdy[d]),   32'h1);
         chk($sformatf("reset inst%0d m1HREADY", d), 32'(o_m1rdy[d]),   32'h1);
         chk($sformatf("reset inst%0d HMASTER", d),  32'(o_hmaster[d]), 32'h0);
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;

      // Directed tables
      foreach (vq[i]) begin
         v = vq[i];
         if (v.rst) do_reset();
         apply(v);
         @(negedge HCLK);
         chk($sformatf("row%0d HTRANS", i),   32'(o_htrans[v.dut]),  32'(v.e_trans));
         chk($sformatf("row%0d HADDR", i),    o_haddr[v.dut],        v.e_addr);
         chk($sformatf("row%0d HWDATA", i),   o_hwdata[v.dut],       v.e_wdata);
         chk($sformatf("row%0d HMASTER", i),  32'(o_hmaster[v.dut]), 32'(v.e_mst));
         chk($sformatf("row%0d m0HREADY", i), 32'(o_m0rdy[v.dut]),   32'(v.e_r0));
         chk($sformatf("row%0d m1HREADY", i), 32'(o_m1rdy[v.dut]),   32'(v.e_r1));
         chk($sformatf("row%0d m0HRDATA", i), o_m0rdata[v.dut],      v.rdata);
         @(posedge HCLK); #1;
      end

      // Reset while M0 is parked and M1 owns a data phase
      do_reset();
      apply(vq[2]);
      @(negedge HCLK);
      @(posedge HCLK); #1;
      chk("rstmid pre m0HREADY", 32'(o_m0rdy[0]),   32'h0);
      chk("rstmid pre HMASTER",  32'(o_hmaster[0]), 32'h1);
      #2;
      HRESETn = 1'b0;
      set_idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rstmid inst%0d HTRANS", d),   32'(o_htrans[d]),  32'h0);
         chk($sformatf("rstmid inst%0d m0HREADY", d), 32'(o_m0rdy[d]),   32'h1);
         chk($sformatf("rstmid inst%0d m1HREADY", d), 32'(o_m1rdy[d]),   32'h1);
         chk($sformatf("rstmid inst%0d HMASTER", d),  32'(o_hmaster[d]), 32'h0);
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      m0HTRANS = 2'b10; m0HADDR = 32'h7000;
      @(negedge HCLK);
      chk("rstmid post HTRANS",   32'(o_htrans[0]), 32'h2);
      chk("rstmid post HADDR",    o_haddr[0],       32'h7000);
      chk("rstmid post m0HREADY", 32'(o_m0rdy[0]),  32'h1);
      @(posedge HCLK); #1;

      // Random traffic against the reference model
      do_reset();
      for (int c = 0; c < 500; c++) begin
         m0HTRANS = 2'($urandom_range(0, 3)); m0HADDR = $urandom; m0HSIZE = 3'($urandom_range(0, 2));
         m0HWRITE = 1'($urandom_range(0, 1)); m0HWDATA = $urandom;
         m1HTRANS = 2'($urandom_range(0, 3)); m1HADDR = $urandom; m1HSIZE = 3'($urandom_range(0, 2));
         m1HWRITE = 1'($urandom_range(0, 1)); m1HWDATA = $urandom;
         HREADY = ($urandom_range(0, 3) != 0);
         HRDATA = $urandom;
         @(negedge HCLK);
         model_step(0, c);
         model_step(1, c);
         @(posedge HCLK); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
